// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM programming loader: default widths,
// strobe polarities and the loader state encoding.
package ram_loader_pkg;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 8;

   // The RAM write strobe and MAR load strobe are both active low
   localparam logic WE_ACTIVE   = 1'b0;
   localparam logic LOAD_ACTIVE = 1'b0;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CLR,
      ST_FETCH,
      ST_SETUP,
      ST_WRITE,
      ST_HOLD,
      ST_RD_SETUP,
      ST_RD_WAIT,
      ST_RD_CMP,
      ST_DONE
   } state_t;

   // A run is in progress in every state except the two resting ones
   function automatic logic isRunState(input state_t s);
      return !(s == ST_IDLE || s == ST_DONE);
   endfunction

endpackage

// File: rtl/ram_loader_shadow.sv
// Shadow copy of the image being loaded, so the readback pass has
// something to compare the RAM contents against.
module ram_loader_shadow
   import ram_loader_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Capture each accepted source byte at the address it is destined for;
   // contents are always rewritten before being read, so no reset is needed
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Asynchronous read so the compare happens in the same cycle the RAM
   // word is presented
   always_comb begin
      rd_data_o = mem_q[rd_addr_i];
   end

endmodule

// File: rtl/ram_loader.sv
// RAM programming loader: takes a full image from a valid/ready byte
// stream, writes it into the RAM through the dipswitch port and then
// optionally reads every location back, flagging the first mismatch.
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int WE_PULSE  = 1,
   parameter int READ_LAT  = 1,
   parameter int VERIFY_EN = 1
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [DATA_W-1:0] ram_bus_out,
   output logic              prog_mode,
   output logic [ADDR_W-1:0] dipswitch_addr,
   output logic [DATA_W-1:0] dipswitch_data,
   output logic              write_enable,
   output logic              load_addr_reg,
   output logic              clear_addr_reg,
   output logic              output_enable,
   output logic              busy,
   output logic              done,
   output logic              verify_err,
   output logic [ADDR_W-1:0] err_addr
);

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_PULSE - 1);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic err_q, err_d;
   logic [ADDR_W-1:0] errAddr_q, errAddr_d;

   logic we_q, we_d;
   logic ld_q, ld_d;
   logic clr_q, clr_d;
   logic oe_q, oe_d;
   logic pm_q, pm_d;
   logic rdy_q, rdy_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   logic shadowWe;
   logic [DATA_W-1:0] shadowData;

   ram_loader_shadow #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_shadow (
      .clk      (clk),
      .wr_en_i  (shadowWe),
      .wr_addr_i(addr_q),
      .wr_data_i(in_data),
      .rd_addr_i(addr_q),
      .rd_data_o(shadowData)
   );

   // Sequencing: walk the image one byte at a time through fetch, MAR
   // setup, write pulse and hold, then (optionally) step back through
   // every address reading it out; the counter stretches the write pulse
   // and the read latency wait
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      errAddr_d = errAddr_q;
      shadowWe  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_CLR;
               err_d     = 1'b0;
               errAddr_d = '0;
            end
         end
         ST_CLR: begin
            addr_d  = '0;
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (in_valid && rdy_q) begin
               data_d   = in_data;
               shadowWe = 1'b1;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            cnt_d   = WE_LOAD;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (cnt_q == '0) begin
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            if (addr_q == LAST_ADDR) begin
               if (VERIFY_EN != 0) begin
                  addr_d  = '0;
                  state_d = ST_RD_SETUP;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_RD_SETUP: begin
            cnt_d   = RD_LOAD;
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RD_CMP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RD_CMP: begin
            if ((ram_bus_out != shadowData) && !err_q) begin
               err_d     = 1'b1;
               errAddr_d = addr_q;
            end
            if (addr_q == LAST_ADDR) begin
               state_d = ST_DONE;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = ST_RD_SETUP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Strobes are decoded from the state being entered so that they are
   // registered and line up exactly with that state's cycle
   always_comb begin
      we_d   = ~WE_ACTIVE;
      ld_d   = ~LOAD_ACTIVE;
      clr_d  = 1'b0;
      oe_d   = 1'b0;
      rdy_d  = 1'b0;
      done_d = 1'b0;
      busy_d = isRunState(state_d);
      pm_d   = isRunState(state_d);
      case (state_d)
         ST_CLR:      clr_d  = 1'b1;
         ST_FETCH:    rdy_d  = 1'b1;
         ST_SETUP:    ld_d   = LOAD_ACTIVE;
         ST_WRITE:    we_d   = WE_ACTIVE;
         ST_RD_SETUP: begin
            ld_d = LOAD_ACTIVE;
            oe_d = 1'b1;
         end
         ST_RD_WAIT:  oe_d   = 1'b1;
         ST_DONE:     done_d = 1'b1;
         default:     done_d = 1'b0;
      endcase
   end

   // State, datapath and strobe registers; clear drops any run in
   // progress immediately, releasing the write strobe at the same edge
   always_ff @(posedge clk) begin
      if (clear) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         errAddr_q <= '0;
         we_q      <= ~WE_ACTIVE;
         ld_q      <= ~LOAD_ACTIVE;
         clr_q     <= 1'b0;
         oe_q      <= 1'b0;
         pm_q      <= 1'b0;
         rdy_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         errAddr_q <= errAddr_d;
         we_q      <= we_d;
         ld_q      <= ld_d;
         clr_q     <= clr_d;
         oe_q      <= oe_d;
         pm_q      <= pm_d;
         rdy_q     <= rdy_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Port mapping of the registered outputs
   always_comb begin
      in_ready       = rdy_q;
      prog_mode      = pm_q;
      dipswitch_addr = addr_q;
      dipswitch_data = data_q;
      write_enable   = we_q;
      load_addr_reg  = ld_q;
      clear_addr_reg = clr_q;
      output_enable  = oe_q;
      busy           = busy_q;
      done           = done_q;
      verify_err     = err_q;
      err_addr       = errAddr_q;
   end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: a small RAM model hangs off the programming port,
// a table of load runs is replayed, and every write strobe is checked
// against a queue of bytes handed to the loader.
module tb_ram_loader;

   logic       clk;
   logic       clear;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [7:0] ram_bus_out;
   logic       prog_mode;
   logic [3:0] dipswitch_addr;
   logic [7:0] dipswitch_data;
   logic       write_enable;
   logic       load_addr_reg;
   logic       clear_addr_reg;
   logic       output_enable;
   logic       busy;
   logic       done;
   logic       verify_err;
   logic [3:0] err_addr;

   typedef struct {
      logic [7:0]  base;
      int          stallByte;
      int          stallLen;
      int          midStart;
      logic [15:0] badMask;
      logic        expErr;
      logic [3:0]  expErrAddr;
      int          expCycles;
   } vec_t;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
   } exp_t;

   vec_t vecs[6];
   vec_t reloadVec;
   exp_t expQ[$];

   int total = 0;
   int bad   = 0;

   logic        wipeReq;
   logic [15:0] badMask;
   logic [7:0]  mem [16];
   logic [3:0]  mar;
   logic [7:0]  busQ;

   ram_loader dut (
      .clk           (clk),
      .clear         (clear),
      .start         (start),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .ram_bus_out   (ram_bus_out),
      .prog_mode     (prog_mode),
      .dipswitch_addr(dipswitch_addr),
      .dipswitch_data(dipswitch_data),
      .write_enable  (write_enable),
      .load_addr_reg (load_addr_reg),
      .clear_addr_reg(clear_addr_reg),
      .output_enable (output_enable),
      .busy          (busy),
      .done          (done),
      .verify_err    (verify_err),
      .err_addr      (err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: MAR loaded or cleared by strobes, writes on a low write
   // strobe, registered bus output refreshed while output_enable is high;
   // addresses flagged in badMask read back as 8'hFF
   always @(posedge clk) begin
      if (wipeReq) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      end else if (!write_enable && prog_mode) begin
         mem[mar] <= dipswitch_data;
      end
      if (clear_addr_reg) begin
         mar <= 4'h0;
      end else if (!load_addr_reg && prog_mode) begin
         mar <= dipswitch_addr;
      end
      if (output_enable) begin
         busQ <= badMask[mar] ? 8'hFF : mem[mar];
      end
   end

   assign ram_bus_out = busQ;

   // One comparison: counts it, reports it if wrong
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // One complete load run described by a table record
   task automatic applyStimulus(input vec_t v);
      logic [7:0] img [16];
      int cyc, byteIdx, stallLeft, clrPulses, stallGlitch, overlap;
      bit stalled, stallActive, seenDone;
      exp_t e;
      for (int i = 0; i < 16; i++) img[i] = v.base + 8'(i);
      @(negedge clk);
      wipeReq = 1'b1;
      badMask = v.badMask;
      expQ.delete();
      @(negedge clk);
      wipeReq   = 1'b0;
      start     = 1'b1;
      in_valid  = 1'b0;
      cyc = 0; byteIdx = 0; stallLeft = 0; clrPulses = 0;
      stallGlitch = 0; overlap = 0;
      stalled = 0; stallActive = 0; seenDone = 0;
      while (!seenDone && cyc < 600) begin
         @(negedge clk);
         cyc++;
         start = (v.midStart != 0 && cyc == v.midStart);
         if (clear_addr_reg) clrPulses++;
         if (!write_enable && output_enable) overlap++;
         if (stallActive && (!write_enable || !in_ready)) stallGlitch++;
         if (!write_enable) begin
            if (expQ.size() == 0) begin
               checkOutput("sbUnexpectedWrite", 32'(dipswitch_addr), 32'hFFFF);
            end else begin
               e = expQ.pop_front();
               checkOutput("sbAddr", 32'(dipswitch_addr), 32'(e.addr));
               checkOutput("sbData", 32'(dipswitch_data), 32'(e.data));
            end
         end
         if (done) begin
            seenDone = 1;
            checkOutput("doneCycles", cyc, v.expCycles);
         end
         if (stallLeft > 0) begin
            in_valid = 1'b0;
            stallLeft--;
         end else if (!stalled && byteIdx == v.stallByte && in_ready && v.stallLen > 0) begin
            stalled     = 1;
            stallActive = 1;
            stallLeft   = v.stallLen - 1;
            in_valid    = 1'b0;
         end else begin
            stallActive = 0;
            in_valid    = (byteIdx < 16);
            if (byteIdx < 16) begin
               in_data = img[byteIdx];
               if (in_ready) begin
                  expQ.push_back('{4'(byteIdx), img[byteIdx]});
                  byteIdx++;
               end
            end
         end
      end
      start = 1'b0;
      if (!seenDone) checkOutput("doneTimeout", 32'd0, 32'd1);
      checkOutput("verifyErr", 32'(verify_err), 32'(v.expErr));
      checkOutput("errAddr", 32'(err_addr), 32'(v.expErrAddr));
      checkOutput("sbLeftover", expQ.size(), 0);
      checkOutput("clrPulses", clrPulses, 1);
      checkOutput("weOeOverlap", overlap, 0);
      if (v.stallLen > 0) checkOutput("stallGlitch", stallGlitch, 0);
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("ram[%0d]", i), 32'(mem[i]), 32'(img[i]));
      end
      repeat (3) @(negedge clk);
      checkOutput("doneHeld", {30'd0, done, busy}, 32'h2);
   endtask

   initial begin
      clear    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      wipeReq  = 1'b0;
      badMask  = 16'h0000;

      vecs[0] = '{8'h10, 16, 0, 0,  16'h0000, 1'b0, 4'h0, 114};
      vecs[1] = '{8'h10, 7,  5, 0,  16'h0000, 1'b0, 4'h0, 119};
      vecs[2] = '{8'h10, 16, 0, 0,  16'h1200, 1'b1, 4'h9, 114};
      vecs[3] = '{8'h55, 16, 0, 0,  16'h8001, 1'b1, 4'h0, 114};
      vecs[4] = '{8'hA0, 16, 0, 0,  16'h8000, 1'b1, 4'hF, 114};
      vecs[5] = '{8'h30, 16, 0, 20, 16'h0000, 1'b0, 4'h0, 114};
      reloadVec = '{8'h70, 16, 0, 0, 16'h0000, 1'b0, 4'h0, 114};

      $display("[TB] reset check");
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rstWe", 32'(write_enable), 32'd1);
      checkOutput("rstLd", 32'(load_addr_reg), 32'd1);
      checkOutput("rstOthers",
                  {24'd0, busy, done, in_ready, prog_mode, clear_addr_reg,
                   output_enable, verify_err, 1'b0}, 32'd0);
      checkOutput("rstErrAddr", 32'(err_addr), 32'd0);
      clear = 1'b0;

      for (int k = 0; k < 6; k++) begin
         $display("[TB] table run %0d", k);
         applyStimulus(vecs[k]);
      end

      $display("[TB] clear during write of byte 3");
      begin
         int n;
         bit hit;
         n = 0;
         hit = 0;
         @(negedge clk);
         badMask  = 16'h0000;
         start    = 1'b1;
         in_valid = 1'b1;
         in_data  = 8'h40;
         while (!hit && n < 200) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (!write_enable && dipswitch_addr == 4'h3) hit = 1;
         end
         if (!hit) checkOutput("abortTimeout", 32'd0, 32'd1);
         clear = 1'b1;
         @(negedge clk);
         clear    = 1'b0;
         in_valid = 1'b0;
         checkOutput("abortWe", 32'(write_enable), 32'd1);
         checkOutput("abortIdle", {29'd0, busy, in_ready, prog_mode}, 32'd0);
         repeat (2) @(negedge clk);
         checkOutput("abortStaysIdle", {30'd0, busy, done}, 32'd0);
      end
      applyStimulus(reloadVec);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
